// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Provides the FSM state encoding and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, one write enable, registered read.
// Ports: clk; en (access strobe); we (1=write, 0=read); idx (word index);
//        wdata (write word); q (read word, updated on a read access only).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                q <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: lw/sw data-memory responder with fixed wait states.
// Ports: clk, reset (sync, active-high); mem_read/mem_write/addr/wdata request;
//        rdata/rdata_valid load result; stall pipeline hold; misalign (only
//        when DMEM_MISALIGN_CHECK_EN is defined).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  stall
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign
`endif
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_write;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_hold;
    logic [DATA_WIDTH-1:0] q;
    logic                  req;
    logic                  commit;
    logic                  bad;
    logic                  arr_en;

    assign req    = mem_read | mem_write;
    assign commit = (state == BUSY) && (cnt == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [1:0] off_q;
    logic       unused_addr;
    assign bad         = |off_q;
    assign unused_addr = ^addr[31:DEPTH_LOG2+2];
`else
    logic       unused_addr;
    assign bad         = 1'b0;
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

    // Misaligned stores are suppressed; misaligned loads still read but
    // the result is masked to zero below.
    assign arr_en = commit && !reset && !(op_write && bad);

    dmem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (op_write),
        .idx  (idx_q),
        .wdata(wdata_q),
        .q    (q)
    );

    // The RAM's registered read lands in DONE; afterwards the held copy
    // is presented so rdata survives later stores and idle cycles.
    assign rdata = (state == DONE && !op_write)
                 ? (bad ? '0 : q)
                 : rdata_hold;

    assign stall = !reset && (((state == IDLE) && req) || (state == BUSY));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_hold  <= '0;
            rdata_valid <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            off_q       <= 2'b00;
            misalign    <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            misalign    <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both are raised.
                        op_write <= mem_write;
                        idx_q    <= addr[DEPTH_LOG2+1:2];
                        wdata_q  <= wdata;
                        cnt      <= CNT_W'(WAIT_STATES);
                        state    <= BUSY;
`ifdef DMEM_MISALIGN_CHECK_EN
                        off_q    <= addr[1:0];
`endif
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state       <= DONE;
                        rdata_valid <= !op_write;
`ifdef DMEM_MISALIGN_CHECK_EN
                        misalign    <= bad;
`endif
                    end
                end
                DONE: begin
                    if (!op_write) begin
                        rdata_hold <= rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
